counter_sweep_ctrl: RTL
=======================

# counter_sweep_ctrl

Sequencing controller for the team's bounded 8-bit up/down counter (legal range 10..40, synchronous load, counts one step per clock when not loaded). It drives the counter's `load`/`data`/`u_d` inputs and watches its `count` output to run a programmable number of triangle sweeps between two bounds, with an optional dwell at each endpoint. It sits between a start/abort command interface and the counter, and parks the counter at a fixed value whenever no sweep is running.

## Interface
- No parameters; all widths are fixed.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `start`  in  1  request a sweep run; sampled only in IDLE.
- `abort`  in  1  stop the current run; highest priority after `rst`.
- `lo`  in  8  lower sweep bound; latched on an accepted `start`.
- `hi`  in  8  upper sweep bound; latched on an accepted `start`.
- `sweeps`  in  4  number of lo→hi→lo sweeps, 1..15; latched on start.
- `dwell`  in  4  extra hold cycles at each turnaround, 0..15; latched on start.
- `count_in`  in  8  counter output (feedback).
- `ctr_load`  out  1  counter load enable.
- `ctr_data`  out  8  counter load value.
- `ctr_u_d`  out  1  counter direction; 1 = up.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse when a run completes normally.
- `err`  out  1  one-cycle pulse on a rejected start or a feedback fault.

## Operation
- States: IDLE, PRELOAD, UP, HOLD_HI, DOWN, HOLD_LO, DONE.
- Internal registers:
  - `park` (8 bits, reset 10): value held while idle.
  - latched `lo_r`, `hi_r`, `dwell_r`.
  - `left` (4 bits): sweeps remaining.
  - `dcnt` (4 bits): dwell countdown.
- Outputs are combinational from state, latched config and `count_in`; state and registers are updated on the clock edge.
- IDLE:
  - Drives `ctr_load`=1, `ctr_data`=`park`, `ctr_u_d`=1, which holds the counter.
  - On `start`=1, the config is valid if 10 ≤ `lo` < `hi` ≤ 40 and `sweeps` ≠ 0.
  - Valid config: latch it, set `left`=`sweeps`, go to PRELOAD.
  - Invalid config: stay in IDLE and pulse `err` on the next cycle.
- PRELOAD: `ctr_load`=1, `ctr_data`=`lo_r`; go to UP.
- UP: `ctr_load`=0, `ctr_u_d`=1.
  - When `count_in`==`hi_r` and `dwell_r`=0: drive `ctr_u_d`=0 (the counter steps down next edge) and go to DOWN.
  - When `count_in`==`hi_r` and `dwell_r`>0: drive `ctr_load`=1, `ctr_data`=`hi_r`, set `dcnt`=`dwell_r`−1, go to HOLD_HI.
- HOLD_HI:
  - While `dcnt`>0: `ctr_load`=1, `ctr_data`=`hi_r`, decrement `dcnt`.
  - When `dcnt`==0: `ctr_load`=0, `ctr_u_d`=0, go to DOWN.
  - Net effect: `hi` is visible on `count_in` for exactly `dwell`+1 cycles.
- DOWN: `ctr_load`=0, `ctr_u_d`=0.
  - When `count_in`==`lo_r`, one sweep is complete and `left` is decremented.
  - If `left` was 1: drive `ctr_load`=1, `ctr_data`=`lo_r`, set `park`=`lo_r`, go to DONE.
  - Otherwise the turnaround at `lo` mirrors UP/HOLD_HI, using HOLD_LO and then UP.
- DONE: holds `park`, pulses `done`, then goes to IDLE.
- `busy`=1 in PRELOAD, UP, HOLD_HI, DOWN and HOLD_LO; 0 in IDLE and DONE.
- `abort`=1 in any busy state: set `park`=`count_in`, go to IDLE, no `done`. In the abort cycle itself, drive `ctr_load`=1, `ctr_data`=`count_in`.
- Feedback fault: `count_in` > `hi_r` in UP, or < `lo_r` in DOWN, is handled like abort and also pulses `err`.
- `start` while busy is ignored. `abort` in IDLE is ignored.
- Simultaneous `start` and `abort` in IDLE: `start` is processed.

## Timing
- Reset values: state IDLE, `park`=10, `busy`=0, `done`=0, `err`=0. After reset: `ctr_load`=1, `ctr_data`=10, `ctr_u_d`=1.
- Reset mid-run returns to IDLE and parks at 10. No `done` or `err` is issued.
- Start latency: start accepted at cycle T → PRELOAD at T+1 → `count_in`=`lo` at T+2.
- Run length with `dwell`=0: one sweep takes 2·(hi−lo) cycles from `count_in`=`lo` to `count_in`=`lo`. `done` is asserted one cycle after the final `lo`.
- Each turnaround (both endpoints, except the final `lo`) adds `dwell` cycles.
- `err` and `done` are asserted exactly one cycle each and never in the same cycle.

## Test plan
- Single sweep: lo=12, hi=15, dwell=0, sweeps=1, start at cycle 0 → `count_in` 12,13,14,15,14,13,12 at cycles 2..8; `done` at 9; `busy` 1 for cycles 1..8; counter held at 12 afterwards.
- Dwell and repeat: lo=10, hi=12, dwell=2, sweeps=2 → 12 seen for 3 cycles at each top; the middle 10 seen for 3 cycles; final 10 followed by `done`; 2 peaks in total.
- Invalid starts: (lo=15, hi=15), (lo=9, hi=20), (hi=41) and sweeps=0 each give an `err` pulse; state stays IDLE; the counter is held at the previous `park`.
- Abort at `count_in`=14 while counting up → counter holds 14 from the next cycle; `busy`=0; no `done`; a later idle period keeps 14.
- Fault: force `count_in`=20 in UP with hi=15 → `err` pulse; IDLE; `park`=20.
- Reset during HOLD_HI → IDLE; `ctr_data`=10; `busy`=0; a new `start` is accepted immediately after.

Source files
------------

// File: rtl/counter_sweep_ctrl_if.sv
// Command and counter-feedback bundle for counter_sweep_ctrl.
// The slave modport is the controller; the master modport is the environment that drives commands and owns the counter.
interface counter_sweep_ctrl_if;
  logic       start;
  logic       abort;
  logic [7:0] lo;
  logic [7:0] hi;
  logic [3:0] sweeps;
  logic [3:0] dwell;
  logic [7:0] count_in;
  logic       ctr_load;
  logic [7:0] ctr_data;
  logic       ctr_u_d;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, abort, lo, hi, sweeps, dwell, count_in,
    input  ctr_load, ctr_data, ctr_u_d, busy, done, err
  );

  modport slave (
    input  start, abort, lo, hi, sweeps, dwell, count_in,
    output ctr_load, ctr_data, ctr_u_d, busy, done, err
  );
endinterface

// File: rtl/counter_sweep_ctrl.sv
// Runs a programmable number of lo->hi->lo triangle sweeps on the bounded up/down counter,
// with optional dwell at each turnaround; parks the counter at a held value whenever idle.
module counter_sweep_ctrl (
  input  logic                 clk,
  input  logic                 rst,
  counter_sweep_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRELOAD,
    S_UP,
    S_HOLD_HI,
    S_DOWN,
    S_HOLD_LO,
    S_DONE
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_park, w_park_nxt;
  logic [7:0] r_lo, r_hi;
  logic [3:0] r_dwell;
  logic [3:0] r_left, w_left_nxt;
  logic [3:0] r_dcnt, w_dcnt_nxt;
  logic       r_err, w_err_nxt;
  logic       w_cfg_latch;
  logic       w_cfg_ok;
  logic       w_busy;
  logic       w_fault;
  logic       w_load;
  logic [7:0] w_data;
  logic       w_u_d;

  assign w_cfg_ok = (bus.lo >= 8'd10) && (bus.lo < bus.hi) &&
                    (bus.hi <= 8'd40) && (bus.sweeps != 4'd0);

  assign w_busy = (r_state == S_PRELOAD) || (r_state == S_UP) ||
                  (r_state == S_HOLD_HI) || (r_state == S_DOWN) ||
                  (r_state == S_HOLD_LO);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_park  <= 8'd10;
      r_lo    <= 8'd10;
      r_hi    <= 8'd10;
      r_dwell <= '0;
      r_left  <= '0;
      r_dcnt  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_park  <= w_park_nxt;
      r_left  <= w_left_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_err   <= w_err_nxt;
      if (w_cfg_latch) begin
        r_lo    <= bus.lo;
        r_hi    <= bus.hi;
        r_dwell <= bus.dwell;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_park_nxt  = r_park;
    w_left_nxt  = r_left;
    w_dcnt_nxt  = r_dcnt;
    w_err_nxt   = 1'b0;
    w_cfg_latch = 1'b0;
    w_fault     = 1'b0;
    w_load      = 1'b0;
    w_data      = r_park;
    w_u_d       = 1'b1;

    case (r_state)
      S_IDLE: begin
        w_load = 1'b1;
        if (bus.start) begin
          if (w_cfg_ok) begin
            w_cfg_latch = 1'b1;
            w_left_nxt  = bus.sweeps;
            w_state_nxt = S_PRELOAD;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_PRELOAD: begin
        w_load      = 1'b1;
        w_data      = r_lo;
        w_state_nxt = S_UP;
      end
      S_UP: begin
        if (bus.count_in > r_hi) begin
          w_fault = 1'b1;
        end else if (bus.count_in == r_hi) begin
          if (r_dwell == 4'd0) begin
            w_u_d       = 1'b0;
            w_state_nxt = S_DOWN;
          end else begin
            w_load      = 1'b1;
            w_data      = r_hi;
            w_dcnt_nxt  = r_dwell - 4'd1;
            w_state_nxt = S_HOLD_HI;
          end
        end
      end
      S_HOLD_HI: begin
        if (r_dcnt != 4'd0) begin
          w_load     = 1'b1;
          w_data     = r_hi;
          w_dcnt_nxt = r_dcnt - 4'd1;
        end else begin
          w_u_d       = 1'b0;
          w_state_nxt = S_DOWN;
        end
      end
      S_DOWN: begin
        w_u_d = 1'b0;
        if (bus.count_in < r_lo) begin
          w_fault = 1'b1;
        end else if (bus.count_in == r_lo) begin
          w_left_nxt = r_left - 4'd1;
          if (r_left == 4'd1) begin
            w_load      = 1'b1;
            w_data      = r_lo;
            w_park_nxt  = r_lo;
            w_state_nxt = S_DONE;
          end else if (r_dwell == 4'd0) begin
            w_u_d       = 1'b1;
            w_state_nxt = S_UP;
          end else begin
            w_load      = 1'b1;
            w_data      = r_lo;
            w_dcnt_nxt  = r_dwell - 4'd1;
            w_state_nxt = S_HOLD_LO;
          end
        end
      end
      S_HOLD_LO: begin
        if (r_dcnt != 4'd0) begin
          w_load     = 1'b1;
          w_data     = r_lo;
          w_dcnt_nxt = r_dcnt - 4'd1;
        end else begin
          w_state_nxt = S_UP;
        end
      end
      S_DONE: begin
        w_load      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_load      = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase

    // Abort and feedback faults override whatever the state decided; abort wins, so no err then.
    if (w_busy && (bus.abort || w_fault)) begin
      w_load      = 1'b1;
      w_data      = bus.count_in;
      w_u_d       = 1'b1;
      w_park_nxt  = bus.count_in;
      w_state_nxt = S_IDLE;
      w_err_nxt   = w_fault && !bus.abort;
    end
  end

  assign bus.ctr_load = w_load;
  assign bus.ctr_data = w_data;
  assign bus.ctr_u_d  = w_u_d;
  assign bus.busy     = w_busy;
  assign bus.done     = (r_state == S_DONE);
  assign bus.err      = r_err;

endmodule
